// File: rtl/pc_pkg.sv
// Shared types and helpers for the pc_node endpoint.
// ASCII MAC decode, widths and FSM encodings.
package pc_pkg;

  localparam int MAC_W = 48;
  localparam int HDR_W = 96;
  localparam logic [MAC_W-1:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [3:0] ascii_hex_to_nibble(
    input logic [7:0] c
  );
    logic [3:0] n;
    n = 4'h0;
    unique case (1'b1)
      (c >= 8'h30 && c <= 8'h39): n = 4'(c - 8'h30);
      (c >= 8'h41 && c <= 8'h46): n = 4'(c - 8'h37);
      (c >= 8'h61 && c <= 8'h66): n = 4'(c - 8'h57);
      default:                    n = 4'h0;
    endcase
    return n;
  endfunction

  // Character at [95:88] becomes nibble [47:44]
  function automatic logic [MAC_W-1:0] ascii_to_mac(
    input logic [HDR_W-1:0] a
  );
    logic [MAC_W-1:0] m;
    m = '0;
    for (int i = 0; i < 12; i++) begin
      m[4*i +: 4] = ascii_hex_to_nibble(a[8*i +: 8]);
    end
    return m;
  endfunction

endpackage

// File: rtl/pc_node_if.sv
// Endpoint bus: MAC config, serial lines and receive status.
// slave = the node, master = whatever drives/observes it.
interface pc_if #(
  parameter int DATA_LEN = 656
);
  logic [95:0]          mac_address;
  logic                 rx;
  logic                 tx;
  logic                 rx_valid;
  logic [47:0]          rx_src_mac;
  logic [DATA_LEN-97:0] rx_payload;

  modport slave (
    input  mac_address,
    input  rx,
    output tx,
    output rx_valid,
    output rx_src_mac,
    output rx_payload
  );

  modport master (
    output mac_address,
    output rx,
    input  tx,
    input  rx_valid,
    input  rx_src_mac,
    input  rx_payload
  );
endinterface

// File: rtl/pc_node_serial_rx.sv
// Serial frame receiver with destination address filter.
// Accepted frames update src/payload and pulse valid_o.
module pc_serial_rx
  import pc_pkg::*;
#(
  parameter int DATA_LEN = 656
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rx_i,
  input  logic [MAC_W-1:0]          own_mac_i,
  output logic                      valid_o,
  output logic [MAC_W-1:0]          src_mac_o,
  output logic [DATA_LEN-HDR_W-1:0] payload_o
);

  localparam int PAY_W = DATA_LEN - HDR_W;
  localparam int CW    = $clog2(DATA_LEN);

  rx_state_e               st_q, st_d;
  logic [DATA_LEN-1:0]     sh_q, sh_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [MAC_W-1:0]        src_q, src_d;
  logic [PAY_W-1:0]        pay_q, pay_d;
  logic [MAC_W-1:0]        dst;
  logic                    hit;

  assign dst = sh_q[DATA_LEN-1 -: MAC_W];
  assign hit = (dst == own_mac_i) || (dst == BROADCAST_MAC);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q    <= RX_HUNT;
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      pay_q   <= '0;
    end else begin
      st_q    <= st_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      pay_q   <= pay_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    src_d   = src_q;
    pay_d   = pay_q;
    unique case (st_q)
      RX_HUNT: begin
        if (!rx_i) begin
          st_d  = RX_DATA;
          cnt_d = '0;
        end
      end
      RX_DATA: begin
        sh_d = {sh_q[DATA_LEN-2:0], rx_i};
        if (cnt_q == CW'(DATA_LEN - 1)) begin
          st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        // A low stop bit is a framing error: drop silently
        st_d = RX_HUNT;
        if (rx_i && hit) begin
          valid_d = 1'b1;
          src_d   = sh_q[DATA_LEN-MAC_W-1 -: MAC_W];
          pay_d   = sh_q[PAY_W-1:0];
        end
      end
      default: st_d = RX_HUNT;
    endcase
  end

  assign valid_o   = valid_q;
  assign src_mac_o = src_q;
  assign payload_o = pay_q;

endmodule

// File: rtl/pc_node.sv
// Hub endpoint: repeating serial frame transmitter plus
// filtered serial receiver, MAC given as 12 ASCII hex chars.
module pc_node
  import pc_pkg::*;
#(
  parameter int              data_len = 656,
  parameter logic [MAC_W-1:0] dest_mac = 48'hFFFF_FFFF_FFFF,
  parameter int              tx_gap   = 16
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);

  localparam int PAY_W = data_len - HDR_W;
  localparam int CW    = $clog2(data_len + 1);
  localparam int GW    = $clog2(tx_gap + 1);

  function automatic logic [PAY_W-1:0] mk_payload();
    logic [PAY_W-1:0] p;
    p = '0;
    for (int k = 0; k < PAY_W / 8; k++) begin
      p[PAY_W-1-8*k -: 8] = 8'(k);
    end
    return p;
  endfunction

  localparam logic [PAY_W-1:0] PAYLOAD = mk_payload();

  logic [MAC_W-1:0]    own_mac;
  tx_state_e           st_q, st_d;
  logic                tx_q, tx_d;
  logic [data_len-1:0] sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       gap_q, gap_d;

  assign own_mac = ascii_to_mac(bus.mac_address);

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q  <= TX_IDLE;
      tx_q  <= 1'b1;
      sh_q  <= '0;
      cnt_q <= '0;
      gap_q <= '0;
    end else begin
      st_q  <= st_d;
      tx_q  <= tx_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  end

  // State names the bit currently on the line; the MAC is
  // captured into the shifter together with the start bit.
  always_comb begin
    st_d  = st_q;
    tx_d  = tx_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    unique case (st_q)
      TX_IDLE: begin
        st_d = TX_START;
        tx_d = 1'b0;
        sh_d = {dest_mac, own_mac, PAYLOAD};
      end
      TX_START: begin
        st_d  = TX_DATA;
        tx_d  = sh_q[data_len-1];
        sh_d  = {sh_q[data_len-2:0], 1'b0};
        cnt_d = CW'(1);
      end
      TX_DATA: begin
        if (cnt_q == CW'(data_len)) begin
          st_d = TX_STOP;
          tx_d = 1'b1;
        end else begin
          tx_d  = sh_q[data_len-1];
          sh_d  = {sh_q[data_len-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        st_d  = TX_GAP;
        tx_d  = 1'b1;
        gap_d = GW'(1);
      end
      TX_GAP: begin
        if (gap_q == GW'(tx_gap)) begin
          st_d = TX_START;
          tx_d = 1'b0;
          sh_d = {dest_mac, own_mac, PAYLOAD};
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        st_d = TX_IDLE;
        tx_d = 1'b1;
      end
    endcase
  end

  assign bus.tx = tx_q;

  pc_serial_rx #(
    .DATA_LEN(data_len)
  ) u_rx (
    .clk_i     (clk),
    .rst_ni    (reset),
    .rx_i      (bus.rx),
    .own_mac_i (own_mac),
    .valid_o   (bus.rx_valid),
    .src_mac_o (bus.rx_src_mac),
    .payload_o (bus.rx_payload)
  );

endmodule

// File: tb/tb_pc_node.sv
// Bench for pc_node: loopback vectors, address filter,
// framing error and mid-frame reset, with a scoreboard.
module tb_pc_node;
  import pc_pkg::*;

  localparam int DL  = 656;
  localparam int PW  = DL - 96;
  localparam int PER = DL + 2 + 16;
  localparam int FIRST = DL + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic loop = 1'b1;
  logic ext_rx = 1'b1;

  always #5 clk = ~clk;

  pc_if #(.DATA_LEN(DL)) ia ();
  pc_if #(.DATA_LEN(DL)) ib ();
  pc_if #(.DATA_LEN(DL)) ic ();

  pc_node #(.data_len(DL)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave)
  );
  pc_node #(
    .data_len(DL), .dest_mac(48'h112233445566)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave)
  );
  pc_node #(
    .data_len(DL), .dest_mac(48'h000A959D6816)
  ) dut_c (
    .clk(clk), .reset(reset), .bus(ic.slave)
  );

  assign ia.rx = loop ? ia.tx : ext_rx;
  assign ib.rx = ib.tx;
  assign ic.rx = ic.tx;
  assign ib.mac_address = ia.mac_address;
  assign ic.mac_address = ia.mac_address;

  int total = 0;
  int bad = 0;
  int b_hits = 0;
  int b_zero = 0;

  typedef struct {
    logic [47:0]   src;
    logic [PW-1:0] pay;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [95:0] ascii;
    logic [47:0] mac;
    logic        cval;
  } vec_t;
  vec_t vecs[5];

  logic [PW-1:0] pref;

  task automatic chk(string nm, logic [PW-1:0] act,
                     logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pay_ref();
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < PW / 8; k++) p = {p[PW-9:0], 8'(k)};
    return p;
  endfunction

  always @(negedge clk) begin
    if (ib.rx_valid) b_hits++;
    if (!ib.tx) b_zero++;
    if (ia.rx_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", ia.rx_src_mac, '1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_src", ia.rx_src_mac, e.src);
        chk("sb_payload", ia.rx_payload, e.pay);
      end
    end
  end

  task automatic do_reset(int n);
    @(negedge clk) reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int limit, output int e);
    e = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (ia.rx_valid) begin
        e = i;
        break;
      end
    end
  endtask

  task automatic send(input logic [47:0] d, input logic [47:0] s,
                      input logic [PW-1:0] p, input logic stopb);
    logic [DL-1:0] f;
    f = {d, s, p};
    @(negedge clk) ext_rx = 1'b0;
    for (int b = DL - 1; b >= 0; b--) begin
      @(negedge clk) ext_rx = f[b];
    end
    @(negedge clk) ext_rx = stopb;
    @(negedge clk) ext_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int e;
    pref = pay_ref();
    vecs[0] = '{ascii: "000A959D6816", mac: 48'h000A959D6816, cval: 1'b1};
    vecs[1] = '{ascii: "000a959d6816", mac: 48'h000A959D6816, cval: 1'b1};
    vecs[2] = '{ascii: "00ZA959D6816", mac: 48'h000A959D6816, cval: 1'b1};
    vecs[3] = '{ascii: "0123456789ab", mac: 48'h0123456789AB, cval: 1'b0};
    vecs[4] = '{ascii: "FfEe9g0A1b2C", mac: 48'hFFEE900A1B2C, cval: 1'b0};

    ia.mac_address = vecs[0].ascii;
    repeat (3) @(negedge clk);
    chk("rst_tx", ia.tx, 1);
    chk("rst_valid", ia.rx_valid, 0);
    chk("rst_src", ia.rx_src_mac, 0);
    chk("rst_payload", ia.rx_payload, 0);

    for (int i = 0; i < 5; i++) begin
      ia.mac_address = vecs[i].ascii;
      do_reset(2);
      sb.push_back('{src: vecs[i].mac, pay: pref});
      @(negedge clk);
      chk("tx_start_bit", ia.tx, 0);
      wait_valid(FIRST + 20, e);
      chk("first_valid_edge", e, FIRST);
      chk("c_valid", ic.rx_valid, vecs[i].cval);
      if (vecs[i].cval) chk("c_src", ic.rx_src_mac, vecs[i].mac);
      chk("b_valid", ib.rx_valid, 0);
      sb.push_back('{src: vecs[i].mac, pay: pref});
      @(negedge clk);
      chk("valid_pulse_len", ia.rx_valid, 0);
      wait_valid(PER + 20, e);
      chk("repeat_period", e, PER - 1);
    end

    // External receive: good, bad stop, filtered, unicast
    loop = 1'b0;
    ext_rx = 1'b1;
    ia.mac_address = vecs[0].ascii;
    do_reset(2);
    sb.push_back('{src: 48'h0000AAAA5555, pay: pref});
    send(BROADCAST_MAC, 48'h0000AAAA5555, pref, 1'b1);
    send(BROADCAST_MAC, 48'hBAD0BAD0BAD0, ~pref, 1'b0);
    chk("hold_src_framing", ia.rx_src_mac, 48'h0000AAAA5555);
    chk("hold_pay_framing", ia.rx_payload, pref);
    send(48'h112233445566, 48'h010203040506, ~pref, 1'b1);
    chk("hold_src_filter", ia.rx_src_mac, 48'h0000AAAA5555);
    sb.push_back('{src: 48'h665544332211, pay: ~pref});
    send(48'h000A959D6816, 48'h665544332211, ~pref, 1'b1);
    chk("unicast_src", ia.rx_src_mac, 48'h665544332211);
    chk("sb_drained_ext", sb.size(), 0);

    // Reset in the middle of a looped frame
    loop = 1'b1;
    do_reset(2);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx", ia.tx, 1);
    chk("midrst_valid", ia.rx_valid, 0);
    chk("midrst_src", ia.rx_src_mac, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.push_back('{src: 48'h000A959D6816, pay: pref});
    @(negedge clk);
    chk("midrst_restart", ia.tx, 0);
    wait_valid(FIRST + 20, e);
    chk("midrst_valid_edge", e, FIRST);
    repeat (4) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    chk("b_never_valid", b_hits, 0);
    chk("b_tx_active", b_zero > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_node.md
Name: pc_node

Overview:
- Endpoint ("PC") model for the hub project.
- Converts its 12-character ASCII hex MAC address to a 48-bit binary address.
- Repeatedly transmits a fixed-format frame bit-serially on tx: destination MAC, source MAC, 70-byte payload.
- Receives frames bit-serially on rx, filters them by destination address, and reports accepted frames on status outputs.

Parameters:
- data_len, default 656 ((6+6+70)*8): total frame bits excluding start/stop. Must be a multiple of 8 and at least 104.
- dest_mac, default 48'hFFFF_FFFF_FFFF: destination MAC placed in every transmitted frame.
- tx_gap, default 16: idle cycles (tx=1) between a stop bit and the next start bit. Must be at least 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = in reset).
- mac_address  in  96  12 ASCII hex chars; [95:88] is the most significant nibble.
- rx  in  1  serial receive line, idle high.
- tx  out  1  serial transmit line, idle high, registered.
- rx_valid  out  1  one-cycle pulse when a frame is accepted.
- rx_src_mac  out  48  source MAC of the last accepted frame.
- rx_payload  out  data_len-96  payload of the last accepted frame; first received byte in the MSBs.

Behaviour:
- Reset (reset=0 sampled at a clock edge):
  - tx=1, rx_valid=0, rx_src_mac=0, rx_payload=0.
  - Both state machines go to IDLE; rx is ignored.
- ASCII conversion, per character:
  - '0'-'9' map to 0-9.
  - 'A'-'F' and 'a'-'f' map to 10-15.
  - Any other code maps to 0.
  - "000A959D6816" gives 48'h000A959D6816.
  - The converted MAC is latched at each frame start; mac_address changes mid-frame do not affect that frame.
- Line format, one bit per clock:
  - Start bit 0, then data_len bits MSB-first, then stop bit 1.
  - Frame layout: dest_mac[47:0], own MAC[47:0], payload.
  - Payload byte k (k=0 sent first) equals k mod 256.
- TX FSM, states IDLE, START, DATA, STOP, GAP:
  - Edge 0 is the first edge with reset=1; tx<=0 at edge 0.
  - Data bits go out at edges 1..data_len; stop bit at edge data_len+1.
  - tx=1 during the gap; the next start bit is at edge data_len+2+tx_gap.
  - Frames repeat forever.
- RX FSM, states HUNT, DATA, STOP:
  - HUNT: rx=0 sampled starts a frame.
  - DATA: shift in data_len bits.
  - STOP: if rx=1, the frame is accepted only when the received destination equals the own MAC or 48'hFFFF_FFFF_FFFF.
  - On acceptance: register rx_src_mac and rx_payload, and pulse rx_valid at that same edge.
  - Stop bit 0 is a framing error: discard the frame silently and return to HUNT.
  - After STOP, always return to HUNT; rx must be seen low again to start.
- With tx looped to rx (data_len=656), the start bit is sampled at edge 1 and the stop bit at edge 658. rx_valid is high in the cycle after edge 658.
- Outputs hold their last accepted values until the next acceptance or reset.
- TX and RX are fully independent; a simultaneous transmit and receive has no interaction.
- Reset mid-frame:
  - tx=1 on the next cycle.
  - The partial receive is discarded and no rx_valid is produced.
  - After release, the frame restarts from the start bit.

Decomposition:
- Package pc_pkg:
  - BROADCAST_MAC, MAC_W=48, HDR_W=96.
  - Function ascii_hex_to_nibble.
  - TX and RX state encodings.
- One natural sub-module, pc_serial_rx: the receive FSM, shift register and address filter.
- Transmit FSM and ASCII conversion stay in pc_node.

Test Plan:
- Loopback tx->rx, mac_address="000A959D6816", defaults, release reset -> tx=0 at edge 0; rx_valid pulses once after edge 658; rx_src_mac=48'h000A959D6816; rx_payload bytes 00,01,...,45. Pulse repeats every 658+16 cycles.
- dest_mac=48'h112233445566, loopback -> tx frames continue, rx_valid never asserts.
- dest_mac=48'h000A959D6816 (own address), loopback -> accepted, same outputs as the first scenario.
- Lowercase input "000a959d6816" and invalid char "00ZA959D6816" -> rx_src_mac 48'h000A959D6816 and 48'h000A959D6816 respectively (Z maps to 0).
- External rx drives a valid frame but stop bit 0 -> no rx_valid; outputs unchanged. A following valid frame is accepted.
- reset=0 asserted mid-DATA for 3 cycles -> tx=1, no rx_valid. After release, a full new frame starts with the start bit at the first edge with reset=1.
